// File: rtl/fpu_param_queue.sv
// Parameterised FPU parameter queue: a circular-buffer FIFO with first-word fall-through,
// a one-behind peek port, occupancy status and sticky overflow/underflow flags.
module fpu_param_queue #(
    parameter int DEPTH        = 4,
    parameter int DATA_W       = 37,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enqueue,
    input  logic [DATA_W-1:0]            data_in,
    input  logic                         dequeue,
    input  logic                         flush,
    input  logic                         err_clr,
    output logic [DATA_W-1:0]            data_out,
    output logic [DATA_W-1:0]            peek_out,
    output logic                         peek_valid,
    output logic                         queue_full,
    output logic                         queue_almost_full,
    output logic                         queue_empty,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  peek_ptr;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              is_empty;
    logic              is_full;
    logic              enq_acc;
    logic              deq_acc;
    logic              ovf_evt;
    logic              udf_evt;

    // Status is decoded from the registered count only, never from the request inputs.
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_W'(DEPTH));

    assign deq_acc = dequeue & ~is_empty & ~flush;
    // A full queue still accepts a push when a pop is taken in the same cycle.
    assign enq_acc = enqueue & ~flush & (~is_full | deq_acc);

    assign ovf_evt = enqueue & ~flush & is_full & ~deq_acc;
    assign udf_evt = dequeue & ~flush & is_empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (deq_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({enq_acc, deq_acc})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // A fresh error event wins over a simultaneous clear.
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (ovf_evt) overflow_d  = 1'b1;
        if (udf_evt) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage has no reset so it can map onto plain distributed/LUT memory.
    always_ff @(posedge clk) begin
        if (enq_acc) mem_q[wr_ptr_q] <= data_in;
    end

    assign peek_ptr = rd_ptr_q + PTR_W'(1);

    assign queue_empty       = is_empty;
    assign queue_full        = is_full;
    assign queue_almost_full = (count_q >= CNT_W'(AFULL_THRESH));
    assign peek_valid        = (count_q >= CNT_W'(2));
    assign queue_count       = count_q;
    assign overflow          = overflow_q;
    assign underflow         = underflow_q;

    // Stale storage is masked so idle outputs read as zero.
    assign data_out = is_empty   ? '0 : mem_q[rd_ptr_q];
    assign peek_out = peek_valid ? mem_q[peek_ptr] : '0;

endmodule

// File: tb/tb_fpu_param_queue.sv
// Directed bench for fpu_param_queue (DEPTH=4, DATA_W=37) with a queue scoreboard
// holding every accepted entry until the DUT presents it on data_out.
module tb_fpu_param_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 37;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enqueue, dequeue, flush, err_clr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out, peek_out;
    logic              peek_valid, queue_full, queue_almost_full, queue_empty;
    logic [CNT_W-1:0]  queue_count;
    logic              overflow, underflow;

    int tests = 0;
    int fails = 0;
    logic [DATA_W-1:0] sb [$];

    fpu_param_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AFULL_THRESH(DEPTH-1)) dut (
        .clk(clk), .reset_n(reset_n), .enqueue(enqueue), .data_in(data_in),
        .dequeue(dequeue), .flush(flush), .err_clr(err_clr),
        .data_out(data_out), .peek_out(peek_out), .peek_valid(peek_valid),
        .queue_full(queue_full), .queue_almost_full(queue_almost_full),
        .queue_empty(queue_empty), .queue_count(queue_count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive requests, take the edge, sample 1ns later.
    task automatic step(input logic enq, input logic [DATA_W-1:0] din, input logic deq,
                        input logic fl, input logic clr);
        enqueue = enq; data_in = din; dequeue = deq; flush = fl; err_clr = clr;
        @(posedge clk);
        #1;
        enqueue = 1'b0; dequeue = 1'b0; flush = 1'b0; err_clr = 1'b0; data_in = '0;
    endtask

    task automatic push(input logic [DATA_W-1:0] din);
        sb.push_back(din);
        step(1'b1, din, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_check(input string tag);
        logic [DATA_W-1:0] exp;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(queue_empty), 64'(1'b0));
        end else begin
            exp = sb.pop_front();
            check(tag, 64'(data_out), 64'(exp));
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_empty"}, 64'(queue_empty), 64'(1'b1));
        check({tag, "_full"}, 64'(queue_full), 64'(1'b0));
        check({tag, "_afull"}, 64'(queue_almost_full), 64'(1'b0));
        check({tag, "_peekv"}, 64'(peek_valid), 64'(1'b0));
        check({tag, "_count"}, 64'(queue_count), 64'd0);
        check({tag, "_dout"}, 64'(data_out), 64'd0);
        check({tag, "_peek"}, 64'(peek_out), 64'd0);
        check({tag, "_ovf"}, 64'(overflow), 64'(1'b0));
        check({tag, "_udf"}, 64'(underflow), 64'(1'b0));
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        logic [DATA_W-1:0] pushes [4];
        pushes[0] = 37'h11; pushes[1] = 37'h22; pushes[2] = 37'h33; pushes[3] = 37'h44;

        reset_n = 1'b0;
        enqueue = 1'b0; dequeue = 1'b0; flush = 1'b0; err_clr = 1'b0; data_in = '0;
        #2;
        check_reset_outputs("por");
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        // Fill to full, tracking almost-full and full at each level.
        for (int i = 0; i < 4; i++) begin
            push(pushes[i]);
            $display("[TB] push %0h count=%0d", pushes[i], queue_count);
            check($sformatf("fill_count%0d", i), 64'(queue_count), 64'(i + 1));
            check($sformatf("fill_afull%0d", i), 64'(queue_almost_full), 64'(i + 1 >= 3));
            check($sformatf("fill_full%0d", i), 64'(queue_full), 64'(i + 1 == 4));
        end
        check("fill_dout", 64'(data_out), 64'h11);
        check("fill_peek", 64'(peek_out), 64'h22);
        check("fill_peekv", 64'(peek_valid), 64'(1'b1));

        // Overflow: push while full is dropped.
        step(1'b1, 37'h55, 1'b0, 1'b0, 1'b0);
        $display("[TB] overflow push 55 count=%0d ovf=%0b", queue_count, overflow);
        check("ovf_flag", 64'(overflow), 64'(1'b1));
        check("ovf_count", 64'(queue_count), 64'd4);
        check("ovf_dout", 64'(data_out), 64'h11);

        // Full queue takes simultaneous push and pop.
        check("pushpop_head", 64'(data_out), 64'(sb.pop_front()));
        sb.push_back(37'h66);
        step(1'b1, 37'h66, 1'b1, 1'b0, 1'b0);
        $display("[TB] push66+pop count=%0d", queue_count);
        check("pushpop_count", 64'(queue_count), 64'd4);
        for (int i = 0; i < 4; i++) pop_check($sformatf("drain%0d", i));
        check("drain_empty", 64'(queue_empty), 64'(1'b1));
        check("drain_dout", 64'(data_out), 64'd0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("ovf_clr", 64'(overflow), 64'(1'b0));

        // Pointer wrap: 10 rounds of push-3/pop-3.
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 3; k++) begin
                v = DATA_W'({$urandom, $urandom});
                push(v);
            end
            $display("[TB] wrap round %0d count=%0d", r, queue_count);
            check($sformatf("wrap_count%0d", r), 64'(queue_count), 64'd3);
            for (int k = 0; k < 3; k++) pop_check($sformatf("wrap%0d_%0d", r, k));
        end
        check("wrap_empty", 64'(queue_empty), 64'(1'b1));

        // Underflow and err_clr priority.
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        $display("[TB] empty pop udf=%0b", underflow);
        check("udf_set", 64'(underflow), 64'(1'b1));
        check("udf_count", 64'(queue_count), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("udf_prio", 64'(underflow), 64'(1'b1));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("udf_clr", 64'(underflow), 64'(1'b0));

        // Push+pop on empty behaves as push only.
        sb.push_back(37'h1ABCD);
        step(1'b1, 37'h1ABCD, 1'b1, 1'b0, 1'b0);
        $display("[TB] empty push+pop count=%0d", queue_count);
        check("nobypass_count", 64'(queue_count), 64'd1);
        check("nobypass_peek", 64'(peek_out), 64'd0);
        pop_check("nobypass_pop");

        // Flush overrides push/pop and leaves error flags alone.
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        push(37'hA1);
        push(37'hA2);
        step(1'b1, 37'hA3, 1'b1, 1'b1, 1'b0);
        sb.delete();
        $display("[TB] flush count=%0d", queue_count);
        check("flush_count", 64'(queue_count), 64'd0);
        check("flush_empty", 64'(queue_empty), 64'(1'b1));
        check("flush_dout", 64'(data_out), 64'd0);
        check("flush_udf", 64'(underflow), 64'(1'b1));
        check("flush_ovf", 64'(overflow), 64'(1'b0));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        push(37'h0F0F);
        check("postflush_dout", 64'(data_out), 64'h0F0F);
        pop_check("postflush_pop");

        // Asynchronous reset mid-cycle with entries queued.
        push(37'hB1); push(37'hB2); push(37'hB3);
        check("prereset_count", 64'(queue_count), 64'd3);
        #2;
        reset_n = 1'b0;
        #1;
        $display("[TB] async reset count=%0d", queue_count);
        check_reset_outputs("arst");
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        push(37'h7A);
        $display("[TB] post-reset push 7A dout=%0h", data_out);
        check("arst_dout", 64'(data_out), 64'h7A);
        check("arst_count", 64'(queue_count), 64'd1);
        check("arst_peek", 64'(peek_out), 64'd0);
        pop_check("arst_pop");
        check("final_empty", 64'(queue_empty), 64'(1'b1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
